// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Build option: MULDIV_EARLY_OUT_EN (consumed by muldiv_unit) enables early termination.
package muldiv_pkg;

  // funct3 encoding of the M-extension operations
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  // FSM state encoding kept as plain constants for older tool flows
  typedef logic [1:0] md_state_t;
  localparam md_state_t MD_IDLE = 2'd0;
  localparam md_state_t MD_RUN  = 2'd1;
  localparam md_state_t MD_DONE = 2'd2;

  // Default configuration and its iteration count
  localparam int MD_DATA_WIDTH_DEF = 32;
  localparam int MD_RADIX_BITS_DEF = 1;
  localparam int ITER = MD_DATA_WIDTH_DEF / MD_RADIX_BITS_DEF;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  // MUL low half is sign-agnostic; treating it as signed keeps the fix-up uniform
  function automatic logic is_signed_a(input md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: sign extraction and magnitude per op,
// plus the double-width conditional negate used to fix up the final result.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  md_op_e                  op_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic [DATA_WIDTH-1:0]   abs_a_o,
  output logic [DATA_WIDTH-1:0]   abs_b_o,
  output logic                    sign_a_o,
  output logic                    sign_b_o,
  input  logic [2*DATA_WIDTH-1:0] fix_i,
  input  logic                    fix_neg_i,
  output logic [2*DATA_WIDTH-1:0] fix_o
);

  localparam int W = DATA_WIDTH;

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic fix_lo_zero;

  // Operand magnitudes; the most-negative value maps to its unsigned magnitude
  always_comb begin
    sign_a_o = is_signed_a(op_i) & a_i[W-1];
    sign_b_o = is_signed_b(op_i) & b_i[W-1];
    abs_a_o  = cond_neg(a_i, sign_a_o);
    abs_b_o  = cond_neg(b_i, sign_b_o);
  end

  // 2W negate built from W-wide halves: high half takes the borrow out of the low half
  always_comb begin
    fix_lo_zero      = (fix_i[W-1:0] == '0);
    fix_o[W-1:0]     = cond_neg(fix_i[W-1:0], fix_neg_i);
    fix_o[2*W-1:W]   = fix_neg_i ? (~fix_i[2*W-1:W] + {{(W-1){1'b0}}, fix_lo_zero})
                                 : fix_i[2*W-1:W];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Build option: define MULDIV_EARLY_OUT_EN for data-dependent early termination
// (multiply stops when the remaining multiplier bits are zero, divide skips
// leading-zero groups of the dividend). Results are identical either way.
//
// state   | meaning
// --------+-------------------------------------------------------
// MD_IDLE | waiting for start_i; outputs invalid
// MD_RUN  | shift-add multiply / restoring divide, RADIX_BITS per cycle
// MD_DONE | result_o/tag_o valid and held until ready_i or flush_i
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH_DEF,
  parameter int RADIX_BITS = MD_RADIX_BITS_DEF,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  input  logic                  flush_i,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]  tag_o
);

  localparam int W     = DATA_WIDTH;
  localparam int R     = RADIX_BITS;
  localparam int NITER = W / R;
  localparam int CW    = $clog2(NITER + 1);
  localparam logic [CW-1:0] ITER_CNT = CW'(NITER);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  md_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  md_op_e               op_q, op_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 neg_res_q, neg_res_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         mcand_q, mcand_d;
  logic [W-1:0]         mplier_q, mplier_d;
  logic [W-1:0]         result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;

  md_op_e               op_in;
  logic [W-1:0]         abs_a, abs_b;
  logic                 sign_a, sign_b;
  logic [2*W-1:0]       fix_val, fix_res;
  logic [W-1:0]         result_fixed;

  logic [W+R-1:0]       mul_sum;
  logic [2*W-1:0]       mul_step, mul_final;
  logic [W-1:0]         mplier_shift;
  logic                 last_iter;
  logic [W-1:0]         dv_rem, dv_quo;
  logic [W:0]           dv_trial;

`ifdef MULDIV_EARLY_OUT_EN
  int                   div_skip;

  function automatic int lead_zeros(input logic [W-1:0] v);
    int   n;
    logic found;
    n     = 0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n++;
      end
    end
    return n;
  endfunction
`endif

  assign op_in = md_op_e'(op_i);

  muldiv_operand_prep #(
    .DATA_WIDTH(W)
  ) u_prep (
    .op_i      (op_in),
    .a_i       (a_i),
    .b_i       (b_i),
    .abs_a_o   (abs_a),
    .abs_b_o   (abs_b),
    .sign_a_o  (sign_a),
    .sign_b_o  (sign_b),
    .fix_i     (fix_val),
    .fix_neg_i (neg_res_q),
    .fix_o     (fix_res)
  );

  // One RUN iteration of both datapaths; the FSM picks the one matching op_q
  always_comb begin
    mul_sum      = {{R{1'b0}}, acc_q[2*W-1:W]} +
                   ({{R{1'b0}}, mcand_q} * {{W{1'b0}}, mplier_q[R-1:0]});
    mul_step     = {mul_sum, acc_q[W-1:R]};
    mplier_shift = mplier_q >> R;
    mul_final    = mul_step;
    last_iter    = (cnt_q == CW'(1));
`ifdef MULDIV_EARLY_OUT_EN
    // Remaining iterations would only add zero and shift; apply the shift at once
    if (!is_div(op_q) && (mplier_shift == '0)) begin
      last_iter = 1'b1;
      mul_final = mul_step >> (R * (int'(cnt_q) - 1));
    end
`endif
    dv_rem   = acc_q[2*W-1:W];
    dv_quo   = acc_q[W-1:0];
    dv_trial = '0;
    for (int i = 0; i < R; i++) begin
      dv_trial = {dv_rem, dv_quo[W-1]} - {1'b0, mcand_q};
      if (!dv_trial[W]) begin
        dv_rem = dv_trial[W-1:0];
        dv_quo = {dv_quo[W-2:0], 1'b1};
      end else begin
        dv_rem = {dv_rem[W-2:0], dv_quo[W-1]};
        dv_quo = {dv_quo[W-2:0], 1'b0};
      end
    end
  end

  // Select the magnitude to sign-fix and the half the op returns
  always_comb begin
    if (is_div(op_q)) fix_val = {{W{1'b0}}, (is_rem(op_q) ? dv_rem : dv_quo)};
    else              fix_val = mul_final;
    if (is_div(op_q) || (op_q == MD_MUL)) result_fixed = fix_res[W-1:0];
    else                                  result_fixed = fix_res[2*W-1:W];
  end

  // Next-state and datapath load logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_res_d = neg_res_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    result_d  = result_q;
`ifdef MULDIV_EARLY_OUT_EN
    div_skip  = 0;
`endif
    case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          op_d      = op_in;
          tag_d     = tag_i;
          cnt_d     = ITER_CNT;
          neg_res_d = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
          if (is_div(op_in)) begin
            mcand_d  = abs_b;
            mplier_d = '0;
            acc_d    = {{W{1'b0}}, abs_a};
`ifdef MULDIV_EARLY_OUT_EN
            // Leading zero groups yield zero quotient bits and leave the remainder at 0
            div_skip = lead_zeros(abs_a) / R;
            if (div_skip > NITER - 1) div_skip = NITER - 1;
            acc_d    = {{W{1'b0}}, abs_a << (div_skip * R)};
            cnt_d    = CW'(NITER - div_skip);
`endif
          end else begin
            mcand_d  = abs_a;
            mplier_d = abs_b;
            acc_d    = '0;
          end
          if (is_div(op_in) && (b_i == '0)) begin
            state_d  = MD_DONE;
            result_d = is_rem(op_in) ? a_i : '1;
          end else if (((op_in == MD_DIV) || (op_in == MD_REM)) &&
                       (a_i == MOST_NEG) && (b_i == '1)) begin
            state_d  = MD_DONE;
            result_d = is_rem(op_in) ? '0 : a_i;
          end else begin
            state_d  = MD_RUN;
          end
        end
      end
      MD_RUN: begin
        if (flush_i) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (is_div(op_q)) begin
            acc_d = {dv_rem, dv_quo};
          end else begin
            acc_d    = mul_step;
            mplier_d = mplier_shift;
          end
          if (last_iter) begin
            state_d  = MD_DONE;
            result_d = result_fixed;
          end
        end
      end
      MD_DONE: begin
        if (flush_i || ready_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // Status flags registered from the next state so they are glitch-free
  always_comb begin
    busy_d  = (state_d != MD_IDLE);
    valid_d = (state_d == MD_DONE);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      op_q      <= MD_MUL;
      tag_q     <= '0;
      neg_res_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      neg_res_q <= neg_res_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign tag_o    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written sequences for
// hold, flush, reset and early-termination corner cases.
module tb_muldiv_unit;

  localparam int W        = 32;
  localparam int RB       = 1;
  localparam int TW       = 5;
  localparam int FULL_LAT = W / RB + 1;
  localparam int LIMIT    = FULL_LAT + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [2:0]    op_i = 3'd0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          flush_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          busy_o;
  logic          valid_o;
  logic [W-1:0]  result_o;
  logic [TW-1:0] tag_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit #(
    .DATA_WIDTH(W),
    .RADIX_BITS(RB),
    .TAG_WIDTH (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .tag_i    (tag_i),
    .flush_i  (flush_i),
    .ready_i  (ready_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .tag_o    (tag_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Pulse start and wait (bounded) for valid_o; lat counts the start edge as cycle 1
  task automatic launch_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag, output int lat);
    op_i = op; a_i = a; b_i = b; tag_i = tag; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    check("valid_within_bound", {31'b0, valid_o}, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res,
                        output logic [4:0] tg, output int lat);
    launch_wait(op, a, b, tag, lat);
    res = result_o;
    tg  = tag_o;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("idle_after_ready", {30'b0, busy_o, valid_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [4:0]  tg;
    int          lat;
    int          cnt;

    vecs.push_back('{"mul_7_m3",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
    vecs.push_back('{"mulhu_ff_ff",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"mulh_m1_m1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{"mulhsu_m1_ff",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"mulh_min_min",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0});
    vecs.push_back('{"mul_shift4",    3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0});
    vecs.push_back('{"mulhu_2p32",    3'd3, 32'h80000000, 32'h00000002, 32'h00000001, 1'b0});
    vecs.push_back('{"mul_b1",        3'd0, 32'h0000ABCD, 32'h00000001, 32'h0000ABCD, 1'b0});
    vecs.push_back('{"div_m20_3",     3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 1'b0});
    vecs.push_back('{"rem_m20_3",     3'd6, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 1'b0});
    vecs.push_back('{"div_20_m3",     3'd4, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0});
    vecs.push_back('{"rem_20_m3",     3'd6, 32'd20,       32'hFFFFFFFD, 32'h00000002, 1'b0});
    vecs.push_back('{"divu_100_7",    3'd5, 32'd100,      32'd7,        32'd14,       1'b0});
    vecs.push_back('{"remu_100_7",    3'd7, 32'd100,      32'd7,        32'd2,        1'b0});
    vecs.push_back('{"divu_ff_1",     3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"divu_min_ff",   3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{"div_min_2",     3'd4, 32'h80000000, 32'd2,        32'hC0000000, 1'b0});
    vecs.push_back('{"div_0_5",       3'd4, 32'd0,        32'd5,        32'd0,        1'b0});
    vecs.push_back('{"div_5_0",       3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"rem_5_0",       3'd6, 32'd5,        32'd0,        32'd5,        1'b1});
    vecs.push_back('{"divu_5_0",      3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{"remu_5_0",      3'd7, 32'd5,        32'd0,        32'd5,        1'b1});
    vecs.push_back('{"div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1});
    vecs.push_back('{"rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy_valid", {30'b0, busy_o, valid_o}, 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_tag", {27'b0, tag_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), res, tg, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_tag"}, {27'b0, tg}, 32'(i + 1));
      if (vecs[i].fast) begin
        check({vecs[i].name, "_latency"}, 32'(lat), 32'd1);
      end else begin
`ifdef MULDIV_EARLY_OUT_EN
        check({vecs[i].name, "_latency_range"}, 32'((lat >= 2 && lat <= FULL_LAT) ? 1 : 0), 32'd1);
`else
        check({vecs[i].name, "_latency"}, 32'(lat), 32'(FULL_LAT));
`endif
      end
    end

`ifdef MULDIV_EARLY_OUT_EN
    run_op(3'd0, 32'h0000ABCD, 32'd1, 5'd3, res, tg, lat);
    check("early_mul_b1_latency", 32'(lat), 32'd2);
    check("early_mul_b1_result", res, 32'h0000ABCD);
`endif

    // Hold in DONE with ready low; a start pulse there must be ignored
    launch_wait(3'd0, 32'd7, 32'hFFFFFFFD, 5'd9, lat);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        op_i = 3'd5; a_i = 32'd9; b_i = 32'd2; tag_i = 5'd1; start_i = 1'b1;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      if (!(valid_o && busy_o && result_o == 32'hFFFFFFEB && tag_o == 5'd9)) cnt++;
    end
    check("hold_steady_cycles_bad", 32'(cnt), 32'd0);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("hold_release_idle", {30'b0, busy_o, valid_o}, 32'd0);
    @(posedge clk); #1;
    check("hold_start_not_queued", {31'b0, busy_o}, 32'd0);

    // Flush at RUN cycle 5, then immediate new op
    op_i = 3'd5; a_i = 32'd1000; b_i = 32'd3; tag_i = 5'd2; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (valid_o) cnt++;
    end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_run_idle", {30'b0, busy_o, valid_o}, 32'd0);
    run_op(3'd5, 32'd9, 32'd2, 5'd4, res, tg, lat);
    check("flush_valid_seen", 32'(cnt), 32'd0);
    check("after_flush_divu_9_2", res, 32'd4);
    check("after_flush_tag", {27'b0, tg}, 32'd4);

    // Flush together with start in IDLE suppresses the launch
    op_i = 3'd5; a_i = 32'd9; b_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check("idle_flush_start_busy", {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    check("idle_flush_start_valid", {31'b0, valid_o}, 32'd0);

    // Flush in DONE (fast path) discards the result
    launch_wait(3'd4, 32'd5, 32'd0, 5'd21, lat);
    check("fast_latency", 32'(lat), 32'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_done_idle", {30'b0, busy_o, valid_o}, 32'd0);

    // Reset in the middle of RUN clears every output
    op_i = 3'd0; a_i = 32'h1234; b_i = 32'h5678; tag_i = 5'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'b0, busy_o}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrun_reset_busy_valid", {30'b0, busy_o, valid_o}, 32'd0);
    check("midrun_reset_result", result_o, 32'd0);
    check("midrun_reset_tag", {27'b0, tag_o}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_op(3'd0, 32'h1234, 32'h5678, 5'd7, res, tg, lat);
    check("post_reset_mul", res, 32'h06260060);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
